// File: rtl/uart_ctrl_if.sv
// Register-bus interface for uart_ctrl.
//   cs    : access select, active-high
//   we/re : write/read strobes, qualified by cs (never both high)
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, valid the edge after cs&re
// master drives the strobes; slave (the controller) returns rdata.
interface uart_ctrl_if;
  logic        cs;
  logic        we;
  logic        re;
  logic [2:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;

  modport master (output cs, we, re, addr, wdata, input rdata);
  modport slave  (input cs, we, re, addr, wdata, output rdata);
endinterface

// File: rtl/uart_ctrl.sv
// Single-channel UART controller with TX/RX FIFOs, register bus, sticky errors and irq.
//   clk, rst_n : system clock, synchronous active-low reset
//   bus        : register access (uart_ctrl_if.slave)
//   txd        : serial out, idle high (registered)
//   rxd        : serial in, 2-FF synchronised
//   irq        : level interrupt, active-high
// Map: 0 CTRL, 1 DIV, 2 STATUS, 3 TXDATA, 4 RXDATA, 5 IE, 6 LEVEL, 7 reserved.
module uart_ctrl #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned DIV_RESET  = 867
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_ctrl_if.slave bus,
  output logic       txd,
  input  logic       rxd,
  output logic       irq
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  typedef logic [DIV_WIDTH-1:0] div_w_t;
  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop1, TxStop2} tx_st_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_st_e;

  logic [7:0]  r_ctrl;
  div_w_t      r_div;
  logic [3:0]  r_sticky;  // {tx_overflow, parity_err, frame_err, rx_overrun}
  logic [2:0]  r_ie;
  logic [15:0] r_rdata, w_rdata;

  logic [7:0]    r_tx_mem [FIFO_DEPTH];
  logic [7:0]    r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [CW-1:0] r_tx_cnt, r_rx_cnt;

  tx_st_e r_tx_st;
  div_w_t r_tx_tmr, r_tx_div;
  logic [2:0] r_tx_bit, r_tx_len;
  logic [7:0] r_tx_sh;
  logic r_tx_pen, r_tx_par, r_tx_two, r_txd, w_tx_line;

  rx_st_e r_rx_st;
  div_w_t r_rx_tmr, r_rx_div, w_rx_half;
  logic [DIV_WIDTH:0] w_rx_sum;
  logic [2:0] r_rx_bit, r_rx_len;
  logic [7:0] r_rx_sh;
  logic r_rx_pen, r_rx_odd, r_rx_perr, r_rx_s1, r_rx_s2, r_rx_s3;

  logic w_wr, w_rd, w_wr_ctrl, w_wr_stat, w_wr_txd, w_rd_rxd;
  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty, w_tx_push, w_tx_pop, w_rx_pop;
  logic w_tx_clr, w_rx_clr, w_tx_tick, w_rx_tick, w_rx_line, w_rx_stop_smp, w_rx_push;
  logic w_rx_push_ok;
  logic [3:0] w_set, w_w1c;
  div_w_t w_div_eff;
  logic [7:0] w_wl_mask, w_tx_word;

  assign w_wr      = bus.cs & bus.we;
  assign w_rd      = bus.cs & bus.re;
  assign w_wr_ctrl = w_wr && (bus.addr == 3'd0);
  assign w_wr_stat = w_wr && (bus.addr == 3'd2);
  assign w_wr_txd  = w_wr && (bus.addr == 3'd3);
  assign w_rd_rxd  = w_rd && (bus.addr == 3'd4);
  assign w_tx_clr  = w_wr_ctrl & bus.wdata[8];
  assign w_rx_clr  = w_wr_ctrl & bus.wdata[9];

  assign w_tx_full  = r_tx_cnt == CW'(FIFO_DEPTH);
  assign w_tx_empty = r_tx_cnt == '0;
  assign w_rx_full  = r_rx_cnt == CW'(FIFO_DEPTH);
  assign w_rx_empty = r_rx_cnt == '0;
  assign w_tx_push  = w_wr_txd & ~w_tx_full;
  assign w_tx_pop   = (r_tx_st == TxIdle) & r_ctrl[0] & ~w_tx_empty;
  assign w_rx_pop   = w_rd_rxd & ~w_rx_empty;

  assign w_div_eff = (r_div < div_w_t'(3)) ? div_w_t'(3) : r_div;
  assign w_wl_mask = 8'hFF >> (2'd3 - r_ctrl[6:5]);
  assign w_tx_word = r_tx_mem[r_tx_rp] & w_wl_mask;
  assign w_tx_tick = r_tx_tmr == r_tx_div;
  assign w_rx_tick = r_rx_tmr == r_rx_div;
  assign w_rx_sum  = {1'b0, r_rx_div} + {{DIV_WIDTH{1'b0}}, 1'b1};
  assign w_rx_half = w_rx_sum[DIV_WIDTH:1];
  assign w_rx_line = r_rx_s2;

  // Stop sample is gated by rx_en so an abort on the same edge pushes nothing.
  assign w_rx_stop_smp = (r_rx_st == RxStop) & w_rx_tick & r_ctrl[1];
  assign w_rx_push     = w_rx_stop_smp & w_rx_line;
  assign w_rx_push_ok  = w_rx_push & (~w_rx_full | w_rx_pop);

  assign w_set = {w_wr_txd & w_tx_full, w_rx_push & r_rx_perr, w_rx_stop_smp & ~w_rx_line,
                  w_rx_push & w_rx_full & ~w_rx_pop};
  assign w_w1c = w_wr_stat ? bus.wdata[9:6] : 4'b0;

  assign txd       = r_txd;
  assign bus.rdata = r_rdata;
  assign irq = (r_ie[0] & ~w_rx_empty) | (r_ie[1] & w_tx_empty) | (r_ie[2] & |r_sticky);

  function automatic logic [7:0] sat8(input logic [CW-1:0] c);
    logic [8:0] w;
    w = 9'(c);
    return w[8] ? 8'hFF : w[7:0];
  endfunction

  // Registers and read port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrl <= 8'h60; r_div <= div_w_t'(DIV_RESET); r_ie <= '0; r_sticky <= '0;
      r_rdata <= '0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= bus.wdata[7:0];
      if (w_wr && bus.addr == 3'd1) r_div <= bus.wdata[DIV_WIDTH-1:0];
      if (w_wr && bus.addr == 3'd5) r_ie <= bus.wdata[2:0];
      r_sticky <= (r_sticky & ~w_w1c) | w_set;  // set wins over clear
      r_rdata  <= w_rd ? w_rdata : 16'h0;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.addr)
      3'd0:    w_rdata = {8'h00, r_ctrl};
      3'd1:    w_rdata = 16'(r_div);
      3'd2:    w_rdata = {6'b0, r_sticky, r_rx_st != RxIdle, r_tx_st != TxIdle,
                          w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};
      3'd4:    w_rdata = {7'b0, w_rx_empty, w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp]};
      3'd5:    w_rdata = {13'b0, r_ie};
      3'd6:    w_rdata = {sat8(r_rx_cnt), sat8(r_tx_cnt)};
      default: w_rdata = '0;
    endcase
  end

  // FIFOs: storage is not reset, only pointers and counts.
  always_ff @(posedge clk) begin
    if (w_tx_push)    r_tx_mem[r_tx_wp] <= bus.wdata[7:0];
    if (w_rx_push_ok) r_rx_mem[r_rx_wp] <= r_rx_sh;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || w_tx_clr) begin
      r_tx_wp <= '0; r_tx_rp <= '0; r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
      r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || w_rx_clr) begin
      r_rx_wp <= '0; r_rx_rp <= '0; r_rx_cnt <= '0;
    end else begin
      if (w_rx_push_ok) r_rx_wp <= r_rx_wp + AW'(1);
      if (w_rx_pop)     r_rx_rp <= r_rx_rp + AW'(1);
      r_rx_cnt <= r_rx_cnt + CW'(w_rx_push_ok) - CW'(w_rx_pop);
    end
  end

  // txd is registered from the current state, so it trails the FSM by one clock.
  always_comb begin
    w_tx_line = 1'b1;
    case (r_tx_st)
      TxStart:  w_tx_line = 1'b0;
      TxData:   w_tx_line = r_tx_sh[0];
      TxParity: w_tx_line = r_tx_par;
      default:  w_tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_st <= TxIdle; r_tx_tmr <= '0; r_tx_div <= '0; r_tx_bit <= '0; r_tx_len <= '0;
      r_tx_sh <= '0; r_tx_pen <= 1'b0; r_tx_par <= 1'b0; r_tx_two <= 1'b0; r_txd <= 1'b1;
    end else begin
      r_txd <= w_tx_line;
      if (r_tx_st == TxIdle) begin
        if (w_tx_pop) begin
          r_tx_st  <= TxStart;
          r_tx_tmr <= '0;
          r_tx_sh  <= w_tx_word;
          r_tx_len <= 3'd4 + {1'b0, r_ctrl[6:5]};  // index of last data bit
          r_tx_pen <= r_ctrl[2];
          r_tx_par <= (^w_tx_word) ^ r_ctrl[3];
          r_tx_two <= r_ctrl[4];
          r_tx_div <= w_div_eff;
        end
      end else if (!w_tx_tick) begin
        r_tx_tmr <= r_tx_tmr + div_w_t'(1);
      end else begin
        r_tx_tmr <= '0;
        case (r_tx_st)
          TxStart: begin r_tx_st <= TxData; r_tx_bit <= '0; end
          TxData: begin
            r_tx_sh  <= r_tx_sh >> 1;
            r_tx_bit <= r_tx_bit + 3'd1;
            if (r_tx_bit == r_tx_len) r_tx_st <= r_tx_pen ? TxParity : TxStop1;
          end
          TxParity: r_tx_st <= TxStop1;
          TxStop1:  r_tx_st <= r_tx_two ? TxStop2 : TxIdle;
          default:  r_tx_st <= TxIdle;
        endcase
      end
    end
  end

  // Receiver; loopback feeds the registered txd into the synchroniser.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_st <= RxIdle; r_rx_tmr <= '0; r_rx_div <= '0; r_rx_bit <= '0; r_rx_len <= '0;
      r_rx_sh <= '0; r_rx_pen <= 1'b0; r_rx_odd <= 1'b0; r_rx_perr <= 1'b0;
      r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= r_ctrl[7] ? r_txd : rxd;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
      if (r_rx_st != RxIdle && !r_ctrl[1]) begin
        r_rx_st <= RxIdle;
      end else begin
        case (r_rx_st)
          RxIdle: begin
            if (r_ctrl[1] && r_rx_s3 && !r_rx_s2) begin
              r_rx_st   <= RxStart;
              r_rx_tmr  <= '0;
              r_rx_sh   <= '0;
              r_rx_perr <= 1'b0;
              r_rx_len  <= 3'd4 + {1'b0, r_ctrl[6:5]};
              r_rx_pen  <= r_ctrl[2];
              r_rx_odd  <= r_ctrl[3];
              r_rx_div  <= w_div_eff;
            end
          end
          RxStart: begin
            if (r_rx_tmr == w_rx_half) begin
              r_rx_tmr <= '0;
              r_rx_bit <= '0;
              r_rx_st  <= w_rx_line ? RxIdle : RxData;  // high here means a glitch
            end else begin
              r_rx_tmr <= r_rx_tmr + div_w_t'(1);
            end
          end
          default: begin
            if (!w_rx_tick) begin
              r_rx_tmr <= r_rx_tmr + div_w_t'(1);
            end else begin
              r_rx_tmr <= '0;
              case (r_rx_st)
                RxData: begin
                  r_rx_sh[r_rx_bit] <= w_rx_line;
                  r_rx_bit <= r_rx_bit + 3'd1;
                  if (r_rx_bit == r_rx_len) r_rx_st <= r_rx_pen ? RxParity : RxStop;
                end
                RxParity: begin
                  r_rx_perr <= w_rx_line ^ (^r_rx_sh) ^ r_rx_odd;
                  r_rx_st   <= RxStop;
                end
                default: r_rx_st <= RxIdle;
              endcase
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_ctrl.sv
// Scoreboard bench for uart_ctrl: stimulus pushes expected read data / txd levels into
// queues, a monitor pops and compares whenever the DUT presents a read result or txd sample.
module tb_uart_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic txd, rxd, irq;
  uart_ctrl_if u_bus ();

  uart_ctrl #(.FIFO_DEPTH(16), .DIV_WIDTH(16), .DIV_RESET(867)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(u_bus), .txd(txd), .rxd(rxd), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  logic    tx_q[$];
  int      errors = 0;
  int      checks = 0;
  logic    rd_seen = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // Monitor: a read sampled at a posedge presents rdata for the following negedge.
  always @(posedge clk) rd_seen <= u_bus.cs & u_bus.re;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (rd_q.size() == 0) begin
        check("unexpected_read", u_bus.rdata, 16'hxxxx);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        check(e.name, u_bus.rdata, e.exp);
      end
    end
    if (tx_q.size() != 0) begin
      logic b;
      b = tx_q.pop_front();
      check("txd_wave", {15'b0, txd}, {15'b0, b});
    end
  end

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    u_bus.cs = 1'b1; u_bus.we = 1'b1; u_bus.addr = a; u_bus.wdata = d;
    @(negedge clk);
    u_bus.cs = 1'b0; u_bus.we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
    rd_exp_t e;
    @(negedge clk);
    u_bus.cs = 1'b1; u_bus.re = 1'b1; u_bus.addr = a;
    @(posedge clk);
    e.name = name; e.exp = exp;
    rd_q.push_back(e);
    @(negedge clk);
    u_bus.cs = 1'b0; u_bus.re = 1'b0;
  endtask

  // TXDATA write with the expected per-clock txd waveform (DIV=3, 8N1).
  task automatic send_tx_checked(input logic [7:0] d);
    @(negedge clk);
    u_bus.cs = 1'b1; u_bus.we = 1'b1; u_bus.addr = 3'd3; u_bus.wdata = {8'h00, d};
    @(posedge clk);
    tx_q.push_back(1'b1); tx_q.push_back(1'b1);
    repeat (4) tx_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (4) tx_q.push_back(d[i]);
    repeat (6) tx_q.push_back(1'b1);
    @(negedge clk);
    u_bus.cs = 1'b0; u_bus.we = 1'b0;
  endtask

  // Drive one rxd frame at 8 clocks per bit (DIV=7); call at a negedge.
  task automatic send_rx(input logic [7:0] d, input bit has_par, input logic par,
                         input logic stop);
    rxd = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (8) @(negedge clk);
    end
    if (has_par) begin
      rxd = par;
      repeat (8) @(negedge clk);
    end
    rxd = stop;
    repeat (8) @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    u_bus.cs = 1'b0; u_bus.we = 1'b0; u_bus.re = 1'b0; u_bus.addr = '0; u_bus.wdata = '0;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state.
    check("reset_txd", {15'b0, txd}, 16'h0001);
    check("reset_irq", {15'b0, irq}, 16'h0000);
    check("idle_rdata", u_bus.rdata, 16'h0000);
    rd(3'd0, 16'h0060, "reset_ctrl");
    rd(3'd1, 16'h0363, "reset_div");
    rd(3'd2, 16'h0005, "reset_status");
    rd(3'd3, 16'h0000, "reset_txdata");
    rd(3'd4, 16'h0100, "reset_rxdata");
    rd(3'd5, 16'h0000, "reset_ie");
    rd(3'd6, 16'h0000, "reset_level");
    rd(3'd7, 16'h0000, "reset_addr7");

    // TX waveform, DIV=3, 8N1, 0xA5.
    wr(3'd1, 16'd3);
    rd(3'd1, 16'h0003, "div_rb");
    wr(3'd0, 16'h0061);
    send_tx_checked(8'hA5);
    for (int i = 0; i < 200 && tx_q.size() != 0; i++) @(negedge clk);
    check("tx_wave_drained", 16'(tx_q.size()), 16'h0000);
    rd(3'd2, 16'h0005, "tx_busy_clear");

    // Loopback, DIV=7, 7E2, 0x3C.
    wr(3'd1, 16'd7);
    wr(3'd0, 16'h00D7);
    wr(3'd3, 16'h003C);
    repeat (150) @(negedge clk);
    rd(3'd6, 16'h0100, "lb_level");
    rd(3'd4, 16'h003C, "lb_rxdata");
    rd(3'd4, 16'h0100, "lb_rx_empty");
    rd(3'd2, 16'h0005, "lb_no_errors");

    // TX overflow with tx_en=0.
    wr(3'd0, 16'h0060);
    for (int i = 0; i < 17; i++) wr(3'd3, 16'(i));
    rd(3'd6, 16'h0010, "ovf_level");
    rd(3'd2, 16'h0206, "ovf_status");
    wr(3'd2, 16'h0200);
    rd(3'd2, 16'h0006, "ovf_w1c");
    wr(3'd0, 16'h0160);
    rd(3'd6, 16'h0000, "txclr_level");
    rd(3'd0, 16'h0060, "txclr_selfclear");

    // Frame error then parity error, 8E1 on rxd.
    wr(3'd0, 16'h0066);
    @(negedge clk);
    send_rx(8'h55, 1'b1, 1'b0, 1'b0);
    rd(3'd2, 16'h0085, "frame_err_status");
    rd(3'd6, 16'h0000, "frame_err_level");
    @(negedge clk);
    send_rx(8'h0F, 1'b1, 1'b1, 1'b1);
    rd(3'd2, 16'h0181, "parity_err_status");
    rd(3'd6, 16'h0100, "parity_err_level");
    check("irq_ie0", {15'b0, irq}, 16'h0000);
    wr(3'd5, 16'h0004);
    check("irq_err", {15'b0, irq}, 16'h0001);
    wr(3'd2, 16'h0180);
    check("irq_err_cleared", {15'b0, irq}, 16'h0000);
    wr(3'd5, 16'h0001);
    check("irq_rx_ne", {15'b0, irq}, 16'h0001);
    rd(3'd4, 16'h000F, "perr_word");
    check("irq_rx_empty", {15'b0, irq}, 16'h0000);
    wr(3'd5, 16'h0000);

    // Fill RX FIFO (8N1), then overrun without and with a coincident pop.
    wr(3'd0, 16'h0062);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      send_rx(8'(8'h10 + i), 1'b0, 1'b0, 1'b1);
    end
    rd(3'd6, 16'h1000, "rx_full_level");
    @(negedge clk);
    send_rx(8'hEE, 1'b0, 1'b0, 1'b1);
    rd(3'd2, 16'h0049, "overrun_status");
    rd(3'd6, 16'h1000, "overrun_level");
    wr(3'd2, 16'h0040);
    // Stop sample falls on the 80th posedge after rxd falls.
    @(negedge clk);
    fork
      send_rx(8'h77, 1'b0, 1'b0, 1'b1);
      begin
        repeat (79) @(posedge clk);
        rd(3'd4, 16'h0010, "pop_at_stop");
      end
    join
    rd(3'd2, 16'h0009, "no_overrun_status");
    rd(3'd6, 16'h1000, "pop_push_level");
    for (int i = 1; i < 16; i++) rd(3'd4, 16'(8'h10 + i), "drain");
    rd(3'd4, 16'h0077, "drain_last");
    rd(3'd4, 16'h0100, "drain_empty");

    // Reset mid-frame.
    wr(3'd1, 16'd7);
    wr(3'd0, 16'h0061);
    wr(3'd3, 16'h0000);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_txd", {15'b0, txd}, 16'h0001);
    rd(3'd0, 16'h0060, "midreset_ctrl");
    rd(3'd1, 16'h0363, "midreset_div");
    rd(3'd2, 16'h0005, "midreset_status");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 16'(rd_q.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
